// File: rtl/uart_sender_if.sv
// uart_sender byte handshake bundle.
// Pipeline side is master, transmitter side is slave.
interface uart_sender_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_sender.sv
// uart_sender: byte FIFO feeding an 8N1 serialiser.
// Frames go out back-to-back while bytes are queued.
module uart_sender #(
  parameter  int BAUD_DIV   = 5208,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_sender_if.slave  bus,
  output logic          uart_tx,
  output logic          tx_busy,
  output logic [CW-1:0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          bit_end;
  logic          has_data;

  assign has_data     = fifo_count != '0;
  assign bit_end      = baud_cnt == BW'(BAUD_DIV - 1);
  assign bus.tx_ready = fifo_count < CW'(FIFO_DEPTH);
  assign push         = bus.tx_valid && bus.tx_ready;
  assign pop          = has_data &&
                        (state == S_IDLE ||
                         (state == S_STOP && bit_end));
  assign tx_busy      = state != S_IDLE;

  // Byte storage; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer: start, 8 data bits LSB first, stop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            state    <= S_START;
            uart_tx  <= 1'b0;
            baud_cnt <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            uart_tx  <= shift[0];
            baud_cnt <= '0;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              uart_tx <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              state   <= S_START;
              uart_tx <= 1'b0;
            end else begin
              state   <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// tb_uart_sender: vector table, corner sequences and
// random traffic against a frame-level reference model.
module tb_uart_sender;

  localparam int B  = 4;
  localparam int D  = 4;
  localparam int FL = 10 * B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_sender_if bus ();

  uart_sender #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       tx;
    logic       busy;
    logic       rdy;
    logic [2:0] cnt;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];
  bit         m_act = 1'b0;
  int         m_el = 0;
  logic [7:0] m_cur = '0;

  bit         dec_on = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_sh = '0;

  int busy_n;
  int run;
  int max_run;

  function automatic logic m_line();
    int k;
    if (!m_act) return 1'b1;
    k = m_el / B;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic decode();
    if (dec_on) begin
      dec_cnt++;
      if (dec_cnt >= B + 1 && dec_cnt < 9 * B &&
          (dec_cnt - 1) % B == 0)
        dec_sh = {uart_tx, dec_sh[7:1]};
      if (dec_cnt == 9 * B + 1) begin
        chk("stop_bit", int'(uart_tx), 1);
        rx_q.push_back(dec_sh);
      end
      if (dec_cnt == FL - 1) dec_on = 1'b0;
    end else if (uart_tx == 1'b0) begin
      dec_on  = 1'b1;
      dec_cnt = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic v,
                     input logic [7:0] d);
    bit push;
    bit load;
    logic e_rdy;
    rst_n        = r;
    bus.tx_valid = v;
    bus.tx_data  = d;
    push = r && v && (mq.size() < D);
    load = r && (mq.size() > 0) &&
           (!m_act || m_el == FL - 1);
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_act  = 1'b0;
      m_el   = 0;
      dec_on = 1'b0;
    end else begin
      if (load) begin
        m_cur = mq.pop_front();
        m_act = 1'b1;
        m_el  = 0;
      end else if (m_act) begin
        if (m_el == FL - 1) m_act = 1'b0;
        else m_el++;
      end
      if (push) begin
        mq.push_back(d);
        acc_q.push_back(d);
      end
    end
    @(negedge clk);
    e_rdy = mq.size() < D;
    n_vec++;
    if (uart_tx !== m_line() || tx_busy !== m_act ||
        bus.tx_ready !== e_rdy ||
        fifo_count !== 3'(mq.size())) begin
      n_err++;
      $display("FAIL model t=%0t tx %b/%b busy %b/%b rdy %b/%b cnt %0d/%0d",
               $time, uart_tx, m_line(), tx_busy, m_act,
               bus.tx_ready, e_rdy, fifo_count, mq.size());
    end
    if (r) decode();
    if (tx_busy) begin
      busy_n++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic chk_rx(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_len"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      chk(nm, int'(rx_q[i]), int'(exp[i]));
  endtask

  vec_t tbl[$];
  int   abits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    logic [7:0] expq[$];
    int sent;
    vec_t t;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    busy_n  = 0;
    run     = 0;
    max_run = 0;

    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0});
    for (int i = 0; i < 20; i++)
      tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 3'd1});
    for (int i = 0; i < FL; i++)
      tbl.push_back('{1'b1, 1'b0, 8'h00, 1'(abits[i / B]),
                      1'b1, 1'b1, 3'd0});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0});

    foreach (tbl[i]) begin
      t = tbl[i];
      cyc(t.r, t.v, t.d);
      n_vec++;
      if (uart_tx !== t.tx || tx_busy !== t.busy ||
          bus.tx_ready !== t.rdy || fifo_count !== t.cnt) begin
        n_err++;
        $display("FAIL table[%0d]: got %b%b%b/%0d want %b%b%b/%0d",
                 i, uart_tx, tx_busy, bus.tx_ready, fifo_count,
                 t.tx, t.busy, t.rdy, t.cnt);
      end
    end
    expq = '{8'hA5};
    chk_rx("a5_rx", expq);

    rx_q.delete();
    busy_n  = 0;
    max_run = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) chk("full_ready", int'(bus.tx_ready), 0);
      cyc(1'b1, 1'b1, 8'(i));
    end
    chk("full_cnt", int'(fifo_count), 4);
    idle(220);
    chk("fill_busy", busy_n, 200);
    chk("fill_run", max_run, 200);
    expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_rx("fill_rx", expq);

    rx_q.delete();
    cyc(1'b1, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 8'h22);
    cyc(1'b1, 1'b1, 8'h33);
    idle(38);
    chk("pp_before", int'(fifo_count), 2);
    cyc(1'b1, 1'b1, 8'h44);
    chk("pp_cnt", int'(fifo_count), 2);
    chk("pp_start", int'(uart_tx), 0);
    idle(4 * FL);
    expq = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk_rx("pp_rx", expq);

    rx_q.delete();
    expq.delete();
    sent = 0;
    for (int c = 0; c < 1000 && sent < 10; c++) begin
      if (fifo_count < 3'd2) begin
        cyc(1'b1, 1'b1, 8'(8'h30 + sent));
        expq.push_back(8'(8'h30 + sent));
        sent++;
      end else begin
        cyc(1'b1, 1'b0, 8'h00);
      end
    end
    chk("wrap_sent", sent, 10);
    idle(4 * FL);
    chk_rx("wrap_rx", expq);

    rx_q.delete();
    cyc(1'b1, 1'b1, 8'h3C);
    cyc(1'b1, 1'b1, 8'h55);
    cyc(1'b1, 1'b1, 8'h66);
    idle(16);
    cyc(1'b0, 1'b0, 8'h00);
    chk("rst_tx", int'(uart_tx), 1);
    chk("rst_cnt", int'(fifo_count), 0);
    chk("rst_busy", int'(tx_busy), 0);
    busy_n = 0;
    idle(3 * FL);
    chk("rst_quiet", busy_n, 0);
    chk("rst_rx", rx_q.size(), 0);

    rx_q.delete();
    acc_q.delete();
    for (int i = 0; i < 1500; i++)
      cyc(1'b1, 1'($urandom_range(0, 3) == 0),
          8'($urandom_range(0, 255)));
    idle(6 * FL);
    chk_rx("rand_rx", acc_q);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
